i2c_target_regfile: RTL and testbench



---
 rtl/i2c_target_regfile_if.sv | 27 ++
 rtl/i2c_target_regfile.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regfile_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_target_regfile_if                                                    |
// | Sideband bundle of the I2C target: SCL input plus status/write strobes.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface i2c_target_regfile_if #(
   parameter int PTR_W = 3
);
   logic             scl;
   logic             busy;
   logic             wr_valid;
   logic [PTR_W-1:0] wr_ptr;
   logic [7:0]       wr_data;
   logic             nack_seen;

   modport master (
      output scl,
      input  busy, wr_valid, wr_ptr, wr_data, nack_seen
   );

   modport slave (
      input  scl,
      output busy, wr_valid, wr_ptr, wr_data, nack_seen
   );
endinterface
`default_nettype wire

// File: rtl/i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_target_regfile                                                       |
// | Oversampling I2C target with a pointer-addressed byte register file.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_target_regfile #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         PTR_W       = 3
) (
   input  wire logic              clk,
   input  wire logic              rst,
   i2c_target_regfile_if.slave    bus,
   inout  wire                    sda
);
   localparam int c_DEPTH = 2 ** PTR_W;

   localparam logic [3:0] c_ST_IDLE      = 4'd0;
   localparam logic [3:0] c_ST_ADDR      = 4'd1;
   localparam logic [3:0] c_ST_ADDR_ACK  = 4'd2;
   localparam logic [3:0] c_ST_PTR       = 4'd3;
   localparam logic [3:0] c_ST_PTR_ACK   = 4'd4;
   localparam logic [3:0] c_ST_WDATA     = 4'd5;
   localparam logic [3:0] c_ST_WDATA_ACK = 4'd6;
   localparam logic [3:0] c_ST_RDATA     = 4'd7;
   localparam logic [3:0] c_ST_RDATA_ACK = 4'd8;
   localparam logic [3:0] c_ST_IGNORE    = 4'd9;

   logic [2:0]       r_scl_q;
   logic [2:0]       r_sda_q;
   logic             r_ev_start;
   logic             r_ev_stop;
   logic             r_ev_rise;
   logic             r_ev_fall;
   logic             r_sda_bit;

   logic [3:0]       r_state;
   logic [3:0]       w_state_nxt;

   logic [7:0]       r_shift;
   logic [2:0]       r_cnt;
   logic [PTR_W-1:0] r_ptr;
   logic             r_phase;
   logic             r_sda_oe;
   logic             r_busy;
   logic             r_wr_valid;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [7:0]       r_wr_data;
   logic             r_nack;
   logic [7:0]       r_mem [c_DEPTH];

   logic [7:0]       w_shift_nxt;
   logic [2:0]       w_cnt_nxt;
   logic [PTR_W-1:0] w_ptr_nxt;
   logic             w_phase_nxt;
   logic             w_sda_oe_nxt;
   logic             w_busy_nxt;
   logic             w_wr_en;
   logic             w_nack;

   logic             w_scl_s;
   logic             w_sda_s;
   logic [7:0]       w_byte;
   logic             w_last;
   logic             w_match;
   logic [7:0]       w_rd_byte;

   // Synchronisers idle high so a reset while the bus is quiet looks like an idle bus
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_q <= 3'b111;
         r_sda_q <= 3'b111;
      end else begin
         r_scl_q <= {r_scl_q[1:0], bus.scl};
         r_sda_q <= {r_sda_q[1:0], sda};
      end
   end

   assign w_scl_s = r_scl_q[1];
   assign w_sda_s = r_sda_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ev_start <= 1'b0;
         r_ev_stop  <= 1'b0;
         r_ev_rise  <= 1'b0;
         r_ev_fall  <= 1'b0;
         r_sda_bit  <= 1'b1;
      end else begin
         r_ev_start <= w_scl_s & r_scl_q[2] & ~w_sda_s & r_sda_q[2];
         r_ev_stop  <= w_scl_s & r_scl_q[2] & w_sda_s & ~r_sda_q[2];
         r_ev_rise  <= w_scl_s & ~r_scl_q[2];
         r_ev_fall  <= ~w_scl_s & r_scl_q[2];
         r_sda_bit  <= w_sda_s;
      end
   end

   assign w_byte    = {r_shift[6:0], r_sda_bit};
   assign w_last    = (r_cnt == 3'd7);
   assign w_match   = (w_byte[7:1] == TARGET_ADDR);
   assign w_rd_byte = r_mem[r_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_ev_start) begin
         w_state_nxt = c_ST_ADDR;
      end else if (r_ev_stop) begin
         w_state_nxt = c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_ADDR: begin
               if (r_ev_rise && w_last) begin
                  w_state_nxt = w_match ? c_ST_ADDR_ACK : c_ST_IGNORE;
               end
            end
            // The address byte is still in the shift register; bit 0 is R/W
            c_ST_ADDR_ACK: begin
               if (r_ev_fall && r_phase) begin
                  w_state_nxt = r_shift[0] ? c_ST_RDATA : c_ST_PTR;
               end
            end
            c_ST_PTR: begin
               if (r_ev_rise && w_last) w_state_nxt = c_ST_PTR_ACK;
            end
            c_ST_PTR_ACK: begin
               if (r_ev_fall && r_phase) w_state_nxt = c_ST_WDATA;
            end
            c_ST_WDATA: begin
               if (r_ev_rise && w_last) w_state_nxt = c_ST_WDATA_ACK;
            end
            c_ST_WDATA_ACK: begin
               if (r_ev_fall && r_phase) w_state_nxt = c_ST_WDATA;
            end
            c_ST_RDATA: begin
               if (r_ev_rise && w_last) w_state_nxt = c_ST_RDATA_ACK;
            end
            c_ST_RDATA_ACK: begin
               if (r_ev_rise && r_phase && r_sda_bit) begin
                  w_state_nxt = c_ST_IGNORE;
               end else if (r_ev_fall && r_phase) begin
                  w_state_nxt = c_ST_RDATA;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      w_shift_nxt  = r_shift;
      w_cnt_nxt    = r_cnt;
      w_ptr_nxt    = r_ptr;
      w_phase_nxt  = r_phase;
      w_sda_oe_nxt = r_sda_oe;
      w_busy_nxt   = r_busy;
      w_wr_en      = 1'b0;
      w_nack       = 1'b0;
      if (r_ev_start || r_ev_stop) begin
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
      end else begin
         case (r_state)
            c_ST_ADDR, c_ST_PTR, c_ST_WDATA: begin
               if (r_ev_rise) begin
                  w_shift_nxt = w_byte;
                  w_cnt_nxt   = r_cnt + 3'd1;
                  if (w_last) begin
                     if (r_state == c_ST_ADDR && w_match) w_busy_nxt = 1'b1;
                     if (r_state == c_ST_PTR) w_ptr_nxt = w_byte[PTR_W-1:0];
                     if (r_state == c_ST_WDATA) begin
                        w_wr_en   = 1'b1;
                        w_ptr_nxt = r_ptr + PTR_W'(1);
                     end
                  end
               end
            end
            // First fall opens the ACK window, second fall closes it
            c_ST_ADDR_ACK, c_ST_PTR_ACK, c_ST_WDATA_ACK: begin
               if (r_ev_fall) begin
                  if (!r_phase) begin
                     w_sda_oe_nxt = 1'b1;
                     w_phase_nxt  = 1'b1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     if (r_state == c_ST_ADDR_ACK && r_shift[0]) begin
                        w_shift_nxt  = w_rd_byte;
                        w_sda_oe_nxt = ~w_rd_byte[7];
                     end
                  end
               end
            end
            c_ST_RDATA: begin
               if (r_ev_rise) begin
                  w_cnt_nxt = r_cnt + 3'd1;
                  if (w_last) w_ptr_nxt = r_ptr + PTR_W'(1);
               end else if (r_ev_fall) begin
                  w_shift_nxt  = {r_shift[6:0], 1'b0};
                  w_sda_oe_nxt = ~r_shift[6];
               end
            end
            c_ST_RDATA_ACK: begin
               if (r_ev_fall) begin
                  if (!r_phase) begin
                     w_sda_oe_nxt = 1'b0;
                     w_phase_nxt  = 1'b1;
                  end else begin
                     w_shift_nxt  = w_rd_byte;
                     w_sda_oe_nxt = ~w_rd_byte[7];
                  end
               end else if (r_ev_rise && r_phase && r_sda_bit) begin
                  w_nack = 1'b1;
               end
            end
            default: w_sda_oe_nxt = 1'b0;
         endcase
      end
      if (r_ev_start || (w_state_nxt != r_state)) begin
         w_cnt_nxt   = 3'd0;
         w_phase_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift    <= 8'h00;
         r_cnt      <= 3'd0;
         r_ptr      <= '0;
         r_phase    <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_ptr   <= '0;
         r_wr_data  <= 8'h00;
         r_nack     <= 1'b0;
      end else begin
         r_shift    <= w_shift_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
         r_phase    <= w_phase_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_busy     <= w_busy_nxt;
         r_wr_valid <= w_wr_en;
         r_nack     <= w_nack;
         if (w_wr_en) begin
            r_wr_ptr  <= r_ptr;
            r_wr_data <= w_byte;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= 8'h00;
      end else if (w_wr_en) begin
         r_mem[r_ptr] <= w_byte;
      end
   end

   assign sda           = r_sda_oe ? 1'b0 : 1'bz;
   assign bus.busy      = r_busy;
   assign bus.wr_valid  = r_wr_valid;
   assign bus.wr_ptr    = r_wr_ptr;
   assign bus.wr_data   = r_wr_data;
   assign bus.nack_seen = r_nack;
endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_target_regfile                                                    |
// | Bit-banged I2C master, vector table and randomized frames vs. a model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_target_regfile;
   localparam int PTR_W = 3;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic m_low = 1'b0;
   wire  sda;

   i2c_target_regfile_if #(.PTR_W(PTR_W)) bus ();

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_target_regfile #(.TARGET_ADDR(7'h50), .PTR_W(PTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .sda (sda)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [6:0]  addr;
      logic [7:0]  ptr;
      int          n;
      logic [23:0] data;
      int          e_ptr;
      logic [23:0] e_data;
   } vec_t;

   typedef struct packed {
      logic [2:0] ptr;
      logic [7:0] data;
   } wr_ev_t;

   int     n_checks = 0;
   int     n_err    = 0;
   wr_ev_t wr_q[$];
   int     nack_cnt = 0;
   bit     dut_drove = 0;
   logic [7:0] ref_mem [DEPTH];
   int     ref_ptr = 0;

   always @(negedge clk) begin
      #1;
      if (bus.wr_valid) wr_q.push_back({bus.wr_ptr, bus.wr_data});
      if (bus.nack_seen) nack_cnt++;
      if (!m_low && sda === 1'b0) dut_drove = 1;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Entered with SCL low just after its falling edge; returns SDA seen mid-high
   task automatic bit_slot(input logic drive_low, output logic seen);
      wait_clk(6);
      m_low = drive_low;
      wait_clk(4);
      bus.scl = 1'b1;
      wait_clk(4);
      seen = sda;
      wait_clk(4);
      bus.scl = 1'b0;
   endtask

   task automatic i2c_start();
      if (bus.scl == 1'b0) begin
         wait_clk(6);
         m_low = 1'b0;
         wait_clk(4);
         bus.scl = 1'b1;
         wait_clk(8);
      end
      m_low = 1'b1;
      wait_clk(8);
      bus.scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(6);
      m_low = 1'b1;
      wait_clk(4);
      bus.scl = 1'b1;
      wait_clk(8);
      m_low = 1'b0;
      wait_clk(12);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) bit_slot(~b[i], s);
      bit_slot(1'b0, s);
      acked = ~s;
   endtask

   task automatic recv_byte(input bit last, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_slot(1'b0, s);
         b[i] = s;
      end
      bit_slot(!last, s);
   endtask

   task automatic write_frame(input logic [6:0] a, input logic [7:0] p, input int n,
                              input logic [23:0] d, output logic [4:0] acks,
                              output logic busy_mid);
      logic k;
      acks = '0;
      i2c_start();
      send_byte({a, 1'b0}, k);
      acks[0]  = k;
      busy_mid = bus.busy;
      send_byte(p, k);
      acks[1] = k;
      for (int i = 0; i < n; i++) begin
         send_byte(d[8*i +: 8], k);
         acks[2+i] = k;
      end
      i2c_stop();
   endtask

   task automatic read_frame(input logic [6:0] a, input logic [7:0] p, input int n,
                             output logic [23:0] got, output logic [2:0] acks,
                             output logic busy_mid);
      logic k;
      logic [7:0] b;
      got = '0;
      i2c_start();
      send_byte({a, 1'b0}, k);
      acks[0] = k;
      send_byte(p, k);
      acks[1] = k;
      i2c_start();
      send_byte({a, 1'b1}, k);
      acks[2]  = k;
      busy_mid = bus.busy;
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, b);
         got[8*i +: 8] = b;
      end
      i2c_stop();
   endtask

   task automatic run_vec(input vec_t v, input bit use_tab, input string tag);
      logic [4:0]  ak;
      logic [2:0]  rk;
      logic        bm;
      logic [23:0] got;
      logic [7:0]  exp_b;
      wr_ev_t      ev;
      int          nk0;
      bit          hit;
      hit = (v.addr == 7'h50);
      wr_q.delete();
      dut_drove = 0;
      nk0 = nack_cnt;
      if (v.rd) begin
         read_frame(v.addr, v.ptr, v.n, got, rk, bm);
         check({tag, " rd addr ack"}, 32'(rk[0]), 32'(hit));
         check({tag, " rd busy"}, 32'(bm), 32'(hit));
         if (hit) begin
            check({tag, " rd ptr/addr ack"}, 32'({rk[1], rk[2]}), 32'd3);
            ref_ptr = int'(v.ptr) % DEPTH;
            for (int i = 0; i < v.n; i++) begin
               exp_b = use_tab ? v.e_data[8*i +: 8] : ref_mem[ref_ptr];
               check($sformatf("%s rd byte%0d", tag, i), 32'(got[8*i +: 8]), 32'(exp_b));
               ref_ptr = (ref_ptr + 1) % DEPTH;
            end
            check({tag, " nack_seen"}, 32'(nack_cnt - nk0), 32'd1);
         end else begin
            check({tag, " sda untouched"}, 32'(dut_drove), 32'd0);
         end
         check({tag, " rd no writes"}, 32'(wr_q.size()), 32'd0);
      end else begin
         write_frame(v.addr, v.ptr, v.n, v.data, ak, bm);
         check({tag, " wr addr ack"}, 32'(ak[0]), 32'(hit));
         check({tag, " wr busy"}, 32'(bm), 32'(hit));
         if (hit) begin
            check({tag, " wr byte acks"}, 32'(ak[1 +: 4] & 4'((1 << (v.n + 1)) - 1)),
                  32'((1 << (v.n + 1)) - 1));
            check({tag, " wr count"}, 32'(wr_q.size()), 32'(v.n));
            ref_ptr = int'(v.ptr) % DEPTH;
            for (int i = 0; i < v.n; i++) begin
               ev = (wr_q.size() > 0) ? wr_q.pop_front() : '1;
               exp_b = use_tab ? v.e_data[8*i +: 8] : v.data[8*i +: 8];
               check($sformatf("%s wr_ptr%0d", tag, i), 32'(ev.ptr),
                     32'(use_tab ? (v.e_ptr + i) % DEPTH : ref_ptr));
               check($sformatf("%s wr_data%0d", tag, i), 32'(ev.data), 32'(exp_b));
               ref_mem[ref_ptr] = v.data[8*i +: 8];
               ref_ptr = (ref_ptr + 1) % DEPTH;
            end
         end else begin
            check({tag, " wr none"}, 32'(wr_q.size()), 32'd0);
            check({tag, " sda untouched"}, 32'(dut_drove), 32'd0);
         end
      end
      check({tag, " busy after stop"}, 32'(bus.busy), 32'd0);
   endtask

   vec_t tab[6];

   initial begin
      logic       s;
      logic       k;
      logic [7:0] b;
      int         lat;
      vec_t       v;

      tab[0] = '{0, 7'h50, 8'h02, 1, 24'h0000A5, 2, 24'h0000A5};
      tab[1] = '{1, 7'h50, 8'h02, 1, 24'h000000, 0, 24'h0000A5};
      tab[2] = '{0, 7'h51, 8'h02, 1, 24'h00003C, 0, 24'h000000};
      tab[3] = '{0, 7'h50, 8'h07, 2, 24'h002211, 7, 24'h002211};
      tab[4] = '{1, 7'h50, 8'h07, 2, 24'h000000, 0, 24'h002211};
      tab[5] = '{1, 7'h50, 8'h0A, 1, 24'h000000, 0, 24'h0000A5};

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      bus.scl = 1'b1;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(2);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset wr_valid", 32'(bus.wr_valid), 32'd0);
      check("reset wr_ptr", 32'(bus.wr_ptr), 32'd0);
      check("reset wr_data", 32'(bus.wr_data), 32'd0);
      check("reset nack_seen", 32'(bus.nack_seen), 32'd0);
      check("reset sda", 32'(sda), 32'd1);

      for (int i = 0; i < 6; i++) run_vec(tab[i], 1'b1, $sformatf("tab%0d", i));

      // wr_valid and ACK-drive latency on a single data byte 0x5B at pointer 3
      b = 8'h5B;
      i2c_start();
      send_byte(8'hA0, k);
      send_byte(8'h03, k);
      wr_q.delete();
      for (int i = 7; i >= 1; i--) bit_slot(~b[i], s);
      wait_clk(6);
      m_low = ~b[0];
      wait_clk(4);
      bus.scl = 1'b1;
      lat = 0;
      while (!bus.wr_valid && lat < 20) begin
         wait_clk(1);
         lat++;
      end
      check("wr_valid latency", 32'(lat), 32'd4);
      wait_clk(1);
      check("wr_valid width", 32'(bus.wr_valid), 32'd0);
      wait_clk(3);
      bus.scl = 1'b0;
      lat = 0;
      while (sda !== 1'b0 && lat < 20) begin
         wait_clk(1);
         lat++;
      end
      check("ack drive latency", 32'(lat), 32'd4);
      wait_clk(10 - lat);
      bus.scl = 1'b1;
      wait_clk(4);
      check("data ack", 32'(sda), 32'd0);
      wait_clk(4);
      bus.scl = 1'b0;
      i2c_stop();
      check("lat wr count", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) check("lat wr event", 32'(wr_q.pop_front()), 32'({3'd3, 8'h5B}));
      ref_mem[3] = 8'h5B;

      // STOP after four bits of a data byte
      i2c_start();
      send_byte(8'hA0, k);
      send_byte(8'h05, k);
      wr_q.delete();
      for (int i = 0; i < 4; i++) bit_slot(i[0], s);
      i2c_stop();
      check("partial no write", 32'(wr_q.size()), 32'd0);
      check("partial busy", 32'(bus.busy), 32'd0);
      v = '{0, 7'h50, 8'h06, 1, 24'h0000C5, 0, 24'h0};
      run_vec(v, 1'b0, "post-partial");

      // Reset while the target drives bit 4 (a 0) of 0xC5
      i2c_start();
      send_byte(8'hA0, k);
      send_byte(8'h06, k);
      i2c_start();
      send_byte(8'hA1, k);
      for (int i = 0; i < 3; i++) bit_slot(1'b0, s);
      wait_clk(6);
      check("rd bit4 driven", 32'(sda), 32'd0);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      check("rst sda released", 32'(sda), 32'd1);
      check("rst busy", 32'(bus.busy), 32'd0);
      wait_clk(4);
      bus.scl = 1'b1;
      wait_clk(8);
      bus.scl = 1'b0;
      i2c_stop();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      ref_ptr = 0;
      v = '{1, 7'h50, 8'h06, 2, 24'h0, 0, 24'h0};
      run_vec(v, 1'b0, "post-rst");

      for (int i = 0; i < 12; i++) begin
         v.rd    = $urandom_range(0, 1) == 1;
         v.addr  = ($urandom_range(0, 4) == 0) ? (7'h50 ^ 7'($urandom_range(1, 127))) : 7'h50;
         v.ptr   = 8'($urandom);
         v.n     = $urandom_range(1, 3);
         v.data  = 24'($urandom);
         v.e_ptr = 0;
         v.e_data = '0;
         run_vec(v, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
